tl_fc_credit_tracker: RTL and testbench
=======================================

# tl_fc_credit_tracker

Parametrised transmit-side flow-control credit gate for the transaction layer. It holds the link partner's advertised credit limits for the Posted, Non-Posted and Completion classes, received as InitFC/UpdateFC values from the DLL. It counts the credits consumed by outgoing TLPs and grants a TLP only when enough header and data credits remain, using modular arithmetic with configurable field widths and infinite-credit handling. It sits between the TLP scheduler and the TX framer.

## Interface
Parameters:
- HDR_W, 8, header credit field width (bits)
- DATA_W, 12, data credit field width (bits); must be ≥ 9
- STALL_W, 16, width of stall statistic counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dl_up  in  1  DLL link up; low forces IDLE
- fc_upd_valid  in  1  InitFC/UpdateFC strobe
- fc_upd_type  in  2  class: 0=P, 1=NP, 2=CPL, 3=illegal
- fc_upd_hdr  in  HDR_W  advertised header credit limit
- fc_upd_data  in  DATA_W  advertised data credit limit
- req_valid  in  1  TLP wants to transmit
- req_type  in  2  class of the TLP, same encoding
- req_has_data  in  1  TLP carries payload
- req_len  in  10  payload length in DW; 0 encodes 1024
- req_ready  out  1  grant; handshake on req_valid & req_ready
- fc_state  out  2  0=IDLE, 1=INIT, 2=ACTIVE
- fc_err  out  1  sticky: illegal type seen on update or request
- stall_cnt_p / stall_cnt_np / stall_cnt_cpl  out  STALL_W each  blocked-cycle counts

## Operation
- Per class, for both header and data: limit register, consumed counter, infinite flag.
- States and transitions:
  - IDLE→INIT on dl_up=1.
  - INIT→ACTIVE once all three classes have received an update while in INIT.
  - Any state→IDLE when dl_up=0: all limits, consumed counters, infinite flags and seen-flags clear. fc_err and stall counters also clear.
- INIT: an update writes the class limit. A field value of 0 sets that field's infinite flag. A repeated update for the same class overwrites the limit and infinite flag.
- ACTIVE: an update overwrites the limit only for non-infinite fields. Infinite fields ignore updates.
- Required credits:
  - Header: 1 per TLP.
  - Data: ceil(len/4) when req_has_data, where len 0 means 1024 (256 credits). Otherwise 0. Zero-extended to DATA_W.
- Field pass condition: infinite, or (limit − (consumed + required)) mod 2^W ≤ 2^(W−1).
- req_ready = (state==ACTIVE) & header pass & data pass, for the class given by req_type.
- On handshake, the class's consumed counters add their required credits, mod 2^W. Infinite fields do not count.
- Type 3 on an update or request:
  - Ignored.
  - req_ready=0.
  - fc_err is set.

## Timing
- Reset values: req_ready=0, fc_state=IDLE, fc_err=0, all stall counters 0, all internal registers 0.
- req_ready is combinational from registered state and the current req_type/req_has_data/req_len. It does not depend on req_valid.
- Consumed counters and limits update on the edge after the handshake or update. Back-to-back grants are allowed: the next cycle's check sees the incremented counter.
- Update and handshake in the same cycle: the grant uses the old limit, and both registers update on the same edge.
- An update unblocks a waiting request in the cycle after fc_upd_valid.
- dl_up falling mid-request: req_ready=0 combinationally (state stays ACTIVE until the edge, but the gate includes dl_up). The state reaches IDLE on the next edge. The requester holds its request; there is no partial grant.

## Configuration
- TL_FC_STATS_EN defined:
  - Each stall_cnt_* increments by 1 on every cycle with req_valid & !req_ready & state==ACTIVE & req_type matching its class.
  - Counters saturate at all-ones and clear on IDLE.
- Not defined: the stall ports remain present, tied to 0. No counter logic is built.

## Structure
- Shared package additions:
  - tl_fc_class_e (FC_P, FC_NP, FC_CPL)
  - tl_fc_state_e (FC_IDLE, FC_INIT, FC_ACTIVE)
  - function fc_data_credits(len, has_data)
- Sub-module tl_fc_credit_chk: one class's header and data limit, consumed counter and infinite flag, with the pass comparison. Instantiated three times, parametrised by HDR_W/DATA_W.

## Test plan
- Init, infinite CPL:
  - Stimulus: dl_up=1; updates P(4,16), NP(2,0), CPL(0,0).
  - Response: fc_state=ACTIVE the cycle after the third update. 100 CPL len=0 requests are all granted. NP data is never checked.
- Header exhaustion:
  - Stimulus: P hdr limit 4; five back-to-back MemWr len=1.
  - Response: grants on cycles 1–4; cycle 5 req_ready=0. UpdateFC P hdr=5 grants it on the next cycle.
- Data rounding:
  - Stimulus: P data limit 16.
  - Response: len=5 consumes 2. len=0 (256 credits) is blocked. Three len=16 grants consume 12, leaving 2; len=9 (3 credits) is blocked.
- Wrap-around:
  - Stimulus: HDR_W=8; drive consumed to 254 via updates and grants, then limit=3.
  - Response: grants continue through 255→0→3; the 6th post-wrap request is blocked.
- Link down mid-operation:
  - Stimulus: blocked request held, then dl_up→0.
  - Response: req_ready=0, IDLE next edge, counters cleared. Re-init returns to ACTIVE with fresh limits.
- Stats:
  - Stimulus: with TL_FC_STATS_EN, an NP request blocked for 10 cycles.
  - Response: stall_cnt_np=10, others 0. Without the macro, all are 0.

Source files
------------

// File: rtl/tl_fc_credit_tracker_pkg.sv
// Shared types and helpers for the transaction-layer flow-control credit tracker.
package tl_fc_credit_tracker_pkg;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } tl_fc_class_e;

    typedef enum logic [1:0] {
        FC_IDLE   = 2'd0,
        FC_INIT   = 2'd1,
        FC_ACTIVE = 2'd2
    } tl_fc_state_e;

    localparam logic [1:0] FC_TYPE_ILLEGAL = 2'd3;

    // One data credit covers 4 DW; a length of 0 means 1024 DW (256 credits).
    function automatic logic [8:0] fc_data_credits(input logic [9:0] len, input logic has_data);
        logic [10:0] dw;
        dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        fc_data_credits = has_data ? 9'((dw + 11'd3) >> 2) : 9'd0;
    endfunction

endpackage

// File: rtl/tl_fc_credit_chk.sv
// One flow-control class: header/data limits, consumed counters, infinite flags and
// the modular "enough credit left" comparison.
module tl_fc_credit_chk #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              upd_i,
    input  logic              upd_init_i,
    input  logic [HDR_W-1:0]  upd_hdr_i,
    input  logic [DATA_W-1:0] upd_data_i,
    input  logic              consume_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              hdr_pass_o,
    output logic              data_pass_o
);

    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    logic [HDR_W-1:0]  hdr_lim_q, hdr_lim_d, hdr_used_q, hdr_used_d;
    logic [DATA_W-1:0] data_lim_q, data_lim_d, data_used_q, data_used_d;
    logic              hdr_inf_q, hdr_inf_d, data_inf_q, data_inf_d;
    logic [HDR_W-1:0]  hdr_room;
    logic [DATA_W-1:0] data_room;

    // Remaining room wraps modulo 2^W; anything above half the space means overdrawn.
    always_comb begin
        hdr_room    = hdr_lim_q - (hdr_used_q + HDR_W'(1));
        data_room   = data_lim_q - (data_used_q + req_data_i);
        hdr_pass_o  = hdr_inf_q  | (hdr_room  <= HDR_HALF);
        data_pass_o = data_inf_q | (data_room <= DATA_HALF);
    end

    always_comb begin
        hdr_lim_d   = hdr_lim_q;
        hdr_used_d  = hdr_used_q;
        hdr_inf_d   = hdr_inf_q;
        data_lim_d  = data_lim_q;
        data_used_d = data_used_q;
        data_inf_d  = data_inf_q;
        if (clr_i) begin
            hdr_lim_d   = '0;
            hdr_used_d  = '0;
            hdr_inf_d   = 1'b0;
            data_lim_d  = '0;
            data_used_d = '0;
            data_inf_d  = 1'b0;
        end else begin
            // Once running, an infinite field keeps its advertisement for the whole link-up.
            if (upd_i) begin
                if (upd_init_i) begin
                    hdr_lim_d  = upd_hdr_i;
                    hdr_inf_d  = (upd_hdr_i == '0);
                    data_lim_d = upd_data_i;
                    data_inf_d = (upd_data_i == '0);
                end else begin
                    if (!hdr_inf_q)  hdr_lim_d  = upd_hdr_i;
                    if (!data_inf_q) data_lim_d = upd_data_i;
                end
            end
            if (consume_i) begin
                if (!hdr_inf_q)  hdr_used_d  = hdr_used_q + HDR_W'(1);
                if (!data_inf_q) data_used_d = data_used_q + req_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_lim_q   <= '0;
            hdr_used_q  <= '0;
            hdr_inf_q   <= 1'b0;
            data_lim_q  <= '0;
            data_used_q <= '0;
            data_inf_q  <= 1'b0;
        end else begin
            hdr_lim_q   <= hdr_lim_d;
            hdr_used_q  <= hdr_used_d;
            hdr_inf_q   <= hdr_inf_d;
            data_lim_q  <= data_lim_d;
            data_used_q <= data_used_d;
            data_inf_q  <= data_inf_d;
        end
    end

endmodule

// File: rtl/tl_fc_credit_tracker.sv
// Transmit-side flow-control credit gate for the P/NP/CPL classes.
// Define TL_FC_STATS_EN to build the per-class blocked-cycle counters.
module tl_fc_credit_tracker
    import tl_fc_credit_tracker_pkg::*;
#(
    parameter int HDR_W   = 8,
    parameter int DATA_W  = 12,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dl_up,
    input  logic               fc_upd_valid,
    input  logic [1:0]         fc_upd_type,
    input  logic [HDR_W-1:0]   fc_upd_hdr,
    input  logic [DATA_W-1:0]  fc_upd_data,
    input  logic               req_valid,
    input  logic [1:0]         req_type,
    input  logic               req_has_data,
    input  logic [9:0]         req_len,
    output logic               req_ready,
    output logic [1:0]         fc_state,
    output logic               fc_err,
    output logic [STALL_W-1:0] stall_cnt_p,
    output logic [STALL_W-1:0] stall_cnt_np,
    output logic [STALL_W-1:0] stall_cnt_cpl
);

    tl_fc_state_e      state_q, state_d;
    logic [2:0]        seen_q, seen_d;
    logic              err_q, err_d;
    logic              upd_ok;
    logic [2:0]        upd_hit, consume, hdr_pass, data_pass;
    logic [DATA_W-1:0] req_data;

    assign upd_ok   = fc_upd_valid & (fc_upd_type != FC_TYPE_ILLEGAL);
    assign req_data = DATA_W'(fc_data_credits(req_len, req_has_data));

    for (genvar k = 0; k < 3; k++) begin : g_cls
        assign upd_hit[k] = upd_ok & (fc_upd_type == 2'(k));
        assign consume[k] = req_valid & req_ready & (req_type == 2'(k));

        tl_fc_credit_chk #(
            .HDR_W (HDR_W),
            .DATA_W(DATA_W)
        ) u_chk (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (!dl_up),
            .upd_i      (upd_hit[k] & (state_q != FC_IDLE)),
            .upd_init_i (state_q == FC_INIT),
            .upd_hdr_i  (fc_upd_hdr),
            .upd_data_i (fc_upd_data),
            .consume_i  (consume[k]),
            .req_data_i (req_data),
            .hdr_pass_o (hdr_pass[k]),
            .data_pass_o(data_pass[k])
        );
    end

    // dl_up is part of the gate so a dropping link never grants in its last cycle.
    always_comb begin
        req_ready = 1'b0;
        if (dl_up && state_q == FC_ACTIVE) begin
            case (req_type)
                2'd0:    req_ready = hdr_pass[0] & data_pass[0];
                2'd1:    req_ready = hdr_pass[1] & data_pass[1];
                2'd2:    req_ready = hdr_pass[2] & data_pass[2];
                default: req_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        err_d   = err_q;
        if (!dl_up) begin
            state_d = FC_IDLE;
            seen_d  = '0;
            err_d   = 1'b0;
        end else begin
            if ((fc_upd_valid && fc_upd_type == FC_TYPE_ILLEGAL) ||
                (req_valid && req_type == FC_TYPE_ILLEGAL)) begin
                err_d = 1'b1;
            end
            case (state_q)
                FC_IDLE: state_d = FC_INIT;
                FC_INIT: begin
                    seen_d = seen_q | upd_hit;
                    if (&seen_d) state_d = FC_ACTIVE;
                end
                FC_ACTIVE: state_d = FC_ACTIVE;
                default:   state_d = FC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FC_IDLE;
            seen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
        end
    end

    assign fc_state = state_q;
    assign fc_err   = err_q;

`ifdef TL_FC_STATS_EN
    logic [2:0][STALL_W-1:0] stall;

    for (genvar k = 0; k < 3; k++) begin : g_stall
        logic [STALL_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (!dl_up || state_q == FC_IDLE) begin
                cnt_d = '0;
            end else if (req_valid && !req_ready && state_q == FC_ACTIVE &&
                         req_type == 2'(k) && cnt_q != '1) begin
                cnt_d = cnt_q + STALL_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign stall[k] = cnt_q;
    end

    assign stall_cnt_p   = stall[0];
    assign stall_cnt_np  = stall[1];
    assign stall_cnt_cpl = stall[2];
`else
    assign stall_cnt_p   = '0;
    assign stall_cnt_np  = '0;
    assign stall_cnt_cpl = '0;
`endif

endmodule

// File: tb/tb_tl_fc_credit_tracker.sv
// Self-checking bench for tl_fc_credit_tracker: directed scenarios plus a randomized
// run, all compared against a credit-accounting model (honours TL_FC_STATS_EN).
module tb_tl_fc_credit_tracker;

    localparam int HDR_W   = 8;
    localparam int DATA_W  = 12;
    localparam int STALL_W = 16;
    localparam int MH      = 1 << HDR_W;
    localparam int MD      = 1 << DATA_W;
    localparam int SMAX    = (1 << STALL_W) - 1;
`ifdef TL_FC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk, rst_n, dl_up;
    logic               fc_upd_valid;
    logic [1:0]         fc_upd_type;
    logic [HDR_W-1:0]   fc_upd_hdr;
    logic [DATA_W-1:0]  fc_upd_data;
    logic               req_valid;
    logic [1:0]         req_type;
    logic               req_has_data;
    logic [9:0]         req_len;
    logic               req_ready;
    logic [1:0]         fc_state;
    logic               fc_err;
    logic [STALL_W-1:0] stall_cnt_p, stall_cnt_np, stall_cnt_cpl;

    int checks = 0;
    int failures = 0;

    // Model of the link partner's credit view, one entry per class.
    int lim_h[3], lim_d[3], used_h[3], used_d[3], m_stall[3];
    bit inf_h[3], inf_d[3], seen[3];
    int m_state = 0;
    bit m_err = 1'b0;

    tl_fc_credit_tracker #(
        .HDR_W(HDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dl_up(dl_up),
        .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type),
        .fc_upd_hdr(fc_upd_hdr), .fc_upd_data(fc_upd_data),
        .req_valid(req_valid), .req_type(req_type), .req_has_data(req_has_data),
        .req_len(req_len), .req_ready(req_ready), .fc_state(fc_state), .fc_err(fc_err),
        .stall_cnt_p(stall_cnt_p), .stall_cnt_np(stall_cnt_np), .stall_cnt_cpl(stall_cnt_cpl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int data_need(bit has_data, int len);
        if (!has_data) return 0;
        if (len == 0) return 256;
        return (len + 3) / 4;
    endfunction

    function automatic bit fits(bit inf, int lim, int used, int need, int m);
        int room;
        room = (lim - used - need) % m;
        if (room < 0) room += m;
        return inf || (room <= m / 2);
    endfunction

    function automatic bit model_ready();
        int t;
        if (!dl_up || m_state != 2 || req_type == 2'd3) return 1'b0;
        t = int'(req_type);
        return fits(inf_h[t], lim_h[t], used_h[t], 1, MH) &&
               fits(inf_d[t], lim_d[t], used_d[t], data_need(req_has_data, int'(req_len)), MD);
    endfunction

    // Apply what the coming clock edge does to the credit view, using present inputs.
    task automatic model_edge();
        bit rdy;
        int t;
        rdy = model_ready();
        if (!dl_up) begin
            for (int i = 0; i < 3; i++) begin
                lim_h[i] = 0; lim_d[i] = 0; used_h[i] = 0; used_d[i] = 0;
                inf_h[i] = 0; inf_d[i] = 0; seen[i] = 0; m_stall[i] = 0;
            end
            m_state = 0;
            m_err = 1'b0;
            return;
        end
        if (STATS && m_state == 2 && req_valid && !rdy && req_type != 2'd3) begin
            t = int'(req_type);
            if (m_stall[t] < SMAX) m_stall[t]++;
        end
        if ((fc_upd_valid && fc_upd_type == 2'd3) || (req_valid && req_type == 2'd3)) m_err = 1'b1;
        if (req_valid && rdy) begin
            t = int'(req_type);
            if (!inf_h[t]) used_h[t] = (used_h[t] + 1) % MH;
            if (!inf_d[t]) used_d[t] = (used_d[t] + data_need(req_has_data, int'(req_len))) % MD;
        end
        if (fc_upd_valid && fc_upd_type != 2'd3) begin
            t = int'(fc_upd_type);
            if (m_state == 1) begin
                lim_h[t] = int'(fc_upd_hdr);  inf_h[t] = (fc_upd_hdr == '0);
                lim_d[t] = int'(fc_upd_data); inf_d[t] = (fc_upd_data == '0);
                seen[t] = 1'b1;
            end else if (m_state == 2) begin
                if (!inf_h[t]) lim_h[t] = int'(fc_upd_hdr);
                if (!inf_d[t]) lim_d[t] = int'(fc_upd_data);
            end
        end
        if (m_state == 0) m_state = 1;
        else if (m_state == 1 && seen[0] && seen[1] && seen[2]) m_state = 2;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit v, int t, bit hd, int len);
        req_valid = v;
        req_type = 2'(t);
        req_has_data = hd;
        req_len = 10'(len);
    endtask

    task automatic do_update(int t, int h, int d);
        fc_upd_valid = 1'b1;
        fc_upd_type = 2'(t);
        fc_upd_hdr = HDR_W'(h);
        fc_upd_data = DATA_W'(d);
        step();
        fc_upd_valid = 1'b0;
    endtask

    task automatic bring_up(int hp, int dp, int hn, int dn, int hc, int dc);
        dl_up = 1'b0;
        step();
        dl_up = 1'b1;
        step();
        do_update(0, hp, dp);
        do_update(1, hn, dn);
        do_update(2, hc, dc);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; dl_up = 1'b0; fc_upd_valid = 1'b0; fc_upd_type = '0;
        fc_upd_hdr = '0; fc_upd_data = '0;
        set_req(1'b0, 0, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || fc_state !== 2'd0 || fc_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ready=%0d state=%0d err=%0d exp 0/0/0", req_ready, fc_state, fc_err);
        end
        checks++;
        if (stall_cnt_p !== '0 || stall_cnt_np !== '0 || stall_cnt_cpl !== '0) begin
            failures++;
            $display("[TB] FAIL reset_stall: got %0d/%0d/%0d exp 0/0/0", stall_cnt_p, stall_cnt_np, stall_cnt_cpl);
        end
        dl_up = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fc_state !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_hold_state: got %0d exp 0", fc_state);
        end
        dl_up = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_init_infinite();
        dl_up = 1'b1;
        step();
        checks++;
        if (fc_state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL init_enter: got state=%0d exp 1", fc_state);
        end
        do_update(0, 4, 16);
        do_update(1, 2, 0);
        checks++;
        if (fc_state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL init_wait_third: got state=%0d exp 1", fc_state);
        end
        do_update(2, 0, 0);
        checks++;
        if (fc_state !== 2'd2) begin
            failures++;
            $display("[TB] FAIL init_active: got state=%0d exp 2", fc_state);
        end
        set_req(1'b1, 2, 1'b1, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL cpl_infinite_grant[%0d]: got ready=%0d exp 1", i, req_ready);
            end
            step();
        end
        set_req(1'b1, 1, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL np_data_infinite: got ready=%0d exp 1", req_ready);
        end
        step();
        set_req(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_hdr_exhaust();
        bring_up(4, 100, 1, 1, 1, 1);
        set_req(1'b1, 0, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (i < 4) || req_ready !== model_ready()) begin
                failures++;
                $display("[TB] FAIL hdr_exhaust[%0d]: got ready=%0d exp %0d", i, req_ready, i < 4);
            end
            step();
        end
        fc_upd_valid = 1'b1; fc_upd_type = 2'd0; fc_upd_hdr = 8'd5; fc_upd_data = 12'd100;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hdr_update_same_cycle: got ready=%0d exp 0", req_ready);
        end
        step();
        fc_upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hdr_update_unblock: got ready=%0d exp 1", req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hdr_reblocked: got ready=%0d exp 0", req_ready);
        end
        set_req(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_data_rounding();
        int lens[8] = '{5, 0, 16, 16, 16, 9, 8, 1};
        bit exps[8] = '{1, 0, 1, 1, 1, 0, 1, 0};
        bring_up(50, 16, 1, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 0, 1'b1, lens[i]);
            @(negedge clk);
            checks++;
            if (req_ready !== exps[i]) begin
                failures++;
                $display("[TB] FAIL data_round len=%0d: got ready=%0d exp %0d", lens[i], req_ready, exps[i]);
            end
            step();
        end
        set_req(1'b1, 0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL data_none_needed: got ready=%0d exp 1", req_ready);
        end
        set_req(1'b0, 0, 1'b0, 0);
        step();
    endtask

    task automatic test_wrap();
        bring_up(127, 0, 1, 1, 1, 1);
        set_req(1'b1, 0, 1'b0, 4);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 127; i++) begin
                @(negedge clk);
                checks++;
                if (req_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL wrap_fill[%0d][%0d]: got ready=%0d exp 1", r, i, req_ready);
                end
                step();
            end
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_fill_stop[%0d]: got ready=%0d exp 0", r, req_ready);
            end
            do_update(0, (r == 0) ? 254 : 3, 0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (i < 5)) begin
                failures++;
                $display("[TB] FAIL wrap_post[%0d]: got ready=%0d exp %0d", i, req_ready, i < 5);
            end
            step();
        end
        set_req(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_link_down();
        bring_up(1, 0, 2, 2, 0, 0);
        set_req(1'b1, 0, 1'b0, 1);
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL linkdn_blocked: got ready=%0d exp 0", req_ready);
        end
        set_req(1'b1, 2, 1'b1, 0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL linkdn_cpl_before: got ready=%0d exp 1", req_ready);
        end
        dl_up = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || fc_state !== 2'd2) begin
            failures++;
            $display("[TB] FAIL linkdn_comb: got ready=%0d state=%0d exp 0/2", req_ready, fc_state);
        end
        set_req(1'b1, 0, 1'b0, 1);
        step();
        checks++;
        if (fc_state !== 2'd0 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL linkdn_idle: got state=%0d ready=%0d exp 0/0", fc_state, req_ready);
        end
        bring_up(1, 0, 1, 1, 1, 1);
        @(negedge clk);
        checks++;
        if (fc_state !== 2'd2 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL linkdn_reinit: got state=%0d ready=%0d exp 2/1", fc_state, req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL linkdn_fresh_limit: got ready=%0d exp 0", req_ready);
        end
        set_req(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_error();
        bring_up(4, 4, 4, 4, 4, 4);
        set_req(1'b1, 3, 1'b0, 1);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || fc_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_req_illegal: got ready=%0d err=%0d exp 0/0", req_ready, fc_err);
        end
        step();
        set_req(1'b0, 0, 1'b0, 0);
        step();
        checks++;
        if (fc_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky: got err=%0d exp 1", fc_err);
        end
        dl_up = 1'b0;
        step();
        checks++;
        if (fc_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear: got err=%0d exp 0", fc_err);
        end
        dl_up = 1'b1;
        step();
        do_update(3, 7, 7);
        checks++;
        if (fc_err !== 1'b1 || fc_state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL err_upd_illegal: got err=%0d state=%0d exp 1/1", fc_err, fc_state);
        end
    endtask

    task automatic test_stats();
        int exp_np;
        bring_up(4, 100, 1, 100, 4, 100);
        set_req(1'b1, 1, 1'b0, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stats_np_blocked[%0d]: got ready=%0d exp 0", i, req_ready);
            end
            step();
        end
        set_req(1'b0, 0, 1'b0, 0);
        @(negedge clk);
        exp_np = STATS ? 10 : 0;
        checks++;
        if (stall_cnt_np !== STALL_W'(exp_np) || stall_cnt_p !== '0 || stall_cnt_cpl !== '0) begin
            failures++;
            $display("[TB] FAIL stats_counts: got p=%0d np=%0d cpl=%0d exp 0/%0d/0",
                     stall_cnt_p, stall_cnt_np, stall_cnt_cpl, exp_np);
        end
        step();
    endtask

    task automatic test_random();
        int t;
        bring_up(8, 40, 8, 40, 8, 40);
        for (int i = 0; i < 3000; i++) begin
            dl_up = ($urandom_range(0, 299) != 0);
            fc_upd_valid = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
            fc_upd_type = 2'(t);
            if (t == 3) begin
                fc_upd_hdr = HDR_W'($urandom);
                fc_upd_data = DATA_W'($urandom);
            end else begin
                fc_upd_hdr = HDR_W'(used_h[t] + int'($urandom_range(0, 6)));
                fc_upd_data = DATA_W'(used_d[t] + int'($urandom_range(0, 60)));
            end
            set_req($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2)),
                    $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40)));
            @(negedge clk);
            checks++;
            if (req_ready !== model_ready()) begin
                failures++;
                $display("[TB] FAIL rand_ready[%0d]: got %0d exp %0d", i, req_ready, model_ready());
            end
            checks++;
            if (fc_state !== 2'(m_state) || fc_err !== m_err) begin
                failures++;
                $display("[TB] FAIL rand_state[%0d]: got state=%0d err=%0d exp %0d/%0d", i, fc_state, fc_err, m_state, m_err);
            end
            checks++;
            if (stall_cnt_p !== STALL_W'(m_stall[0]) || stall_cnt_np !== STALL_W'(m_stall[1]) ||
                stall_cnt_cpl !== STALL_W'(m_stall[2])) begin
                failures++;
                $display("[TB] FAIL rand_stall[%0d]: got %0d/%0d/%0d exp %0d/%0d/%0d", i, stall_cnt_p,
                         stall_cnt_np, stall_cnt_cpl, m_stall[0], m_stall[1], m_stall[2]);
            end
            step();
        end
        fc_upd_valid = 1'b0;
        set_req(1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_init_infinite();
        test_hdr_exhaust();
        test_data_rounding();
        test_wrap();
        test_link_down();
        test_error();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
